// File: rtl/msi_cache_controller_pkg.sv
// Shared encodings for the MSI cache controller: line states, bus commands, FSM states.
package msi_cache_controller_pkg;

  localparam int unsigned LST_W = 2;
  localparam int unsigned CMD_W = 2;
  localparam int unsigned FSM_W = 3;

  localparam logic [LST_W-1:0] MSI_I = 2'b00;
  localparam logic [LST_W-1:0] MSI_S = 2'b01;
  localparam logic [LST_W-1:0] MSI_M = 2'b10;

  localparam logic [CMD_W-1:0] CMD_NONE  = 2'b00;
  localparam logic [CMD_W-1:0] CMD_BUSRD = 2'b01;
  localparam logic [CMD_W-1:0] CMD_RDX   = 2'b10;
  localparam logic [CMD_W-1:0] CMD_WB    = 2'b11;

  localparam logic [FSM_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [FSM_W-1:0] ST_LOOKUP = 3'd1;
  localparam logic [FSM_W-1:0] ST_WB     = 3'd2;
  localparam logic [FSM_W-1:0] ST_MISS   = 3'd3;
  localparam logic [FSM_W-1:0] ST_FILL   = 3'd4;
  localparam logic [FSM_W-1:0] ST_SNOOP  = 3'd5;

  // Encoding 11 is reserved and behaves as Invalid.
  function automatic logic msi_is_valid(input logic [LST_W-1:0] st);
    return (st == MSI_S) || (st == MSI_M);
  endfunction

endpackage

// File: rtl/msi_cache_controller_if.sv
// CPU, line-array, shared-bus and snoop signals of one MSI cache controller.
interface msi_cache_controller_if
  import msi_cache_controller_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned IDX_W  = 1
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;

  logic [IDX_W-1:0]  line_idx;
  logic [LST_W-1:0]  line_state_in;
  logic [ADDR_W-1:0] line_addr_in;
  logic [DATA_W-1:0] line_data_in;
  logic              line_write;
  logic [LST_W-1:0]  line_state;
  logic [ADDR_W-1:0] line_addr;
  logic [DATA_W-1:0] line_data;

  logic              bus_req;
  logic              bus_gnt;
  logic [CMD_W-1:0]  bus_cmd;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_done;

  logic              snoop_valid;
  logic [CMD_W-1:0]  snoop_cmd;
  logic [ADDR_W-1:0] snoop_addr;
  logic              snoop_flush;
  logic [DATA_W-1:0] snoop_data;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rdata,
    output line_idx, line_write, line_state, line_addr, line_data,
    input  line_state_in, line_addr_in, line_data_in,
    output bus_req, bus_cmd, bus_addr, bus_wdata,
    input  bus_gnt, bus_rdata, bus_done,
    input  snoop_valid, snoop_cmd, snoop_addr,
    output snoop_flush, snoop_data
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rdata,
    input  line_idx, line_write, line_state, line_addr, line_data,
    output line_state_in, line_addr_in, line_data_in,
    input  bus_req, bus_cmd, bus_addr, bus_wdata,
    output bus_gnt, bus_rdata, bus_done,
    output snoop_valid, snoop_cmd, snoop_addr,
    input  snoop_flush, snoop_data
  );
endinterface

// File: rtl/msi_cache_controller_snoop_logic.sv
// Snoop response for one line: whether it changes, its new MSI state, and whether to flush.
module msi_cache_controller_snoop_logic
  import msi_cache_controller_pkg::*;
#(
  parameter int unsigned ADDR_W = 3
) (
  input  logic [LST_W-1:0]  i_line_state,
  input  logic [ADDR_W-1:0] i_line_addr,
  input  logic [CMD_W-1:0]  i_snoop_cmd,
  input  logic [ADDR_W-1:0] i_snoop_addr,
  output logic              o_write_c,
  output logic [LST_W-1:0]  o_state_c,
  output logic              o_flush_c
);

  always_comb begin
    o_write_c = 1'b0;
    o_state_c = i_line_state;
    o_flush_c = 1'b0;
    if (msi_is_valid(i_line_state) && (i_line_addr == i_snoop_addr)) begin
      if ((i_line_state == MSI_M) && (i_snoop_cmd == CMD_BUSRD)) begin
        o_write_c = 1'b1;
        o_state_c = MSI_S;
        o_flush_c = 1'b1;
      end else if ((i_line_state == MSI_M) && (i_snoop_cmd == CMD_RDX)) begin
        o_write_c = 1'b1;
        o_state_c = MSI_I;
        o_flush_c = 1'b1;
      end else if ((i_line_state == MSI_S) && (i_snoop_cmd == CMD_RDX)) begin
        o_write_c = 1'b1;
        o_state_c = MSI_I;
      end
    end
  end

endmodule

// File: rtl/msi_cache_controller.sv
// MSI snooping controller for a direct-mapped line array: CPU hits/misses, write-backs, snoops.
module msi_cache_controller
  import msi_cache_controller_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned IDX_W  = 1
) (
  input logic                    i_clk,
  input logic                    i_rst,
  msi_cache_controller_if.master io_if
);

  logic [FSM_W-1:0]  r_state, w_state_n, r_ret, w_ret_n;
  logic              r_we, w_we_n;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic [DATA_W-1:0] r_wdata, w_wdata_n, r_fill, w_fill_n;
  logic [CMD_W-1:0]  r_snp_cmd, w_snp_cmd_n;
  logic [ADDR_W-1:0] r_snp_addr, w_snp_addr_n;

  logic              r_cpu_ready, w_cpu_ready_n;
  logic [DATA_W-1:0] r_cpu_rdata, w_cpu_rdata_n;
  logic [IDX_W-1:0]  r_line_idx, w_line_idx_n;
  logic              r_line_write, w_line_write_n;
  logic [LST_W-1:0]  r_line_state, w_line_state_n;
  logic [ADDR_W-1:0] r_line_addr, w_line_addr_n;
  logic [DATA_W-1:0] r_line_data, w_line_data_n;
  logic              r_bus_req, w_bus_req_n;
  logic [CMD_W-1:0]  r_bus_cmd, w_bus_cmd_n;
  logic [ADDR_W-1:0] r_bus_addr, w_bus_addr_n;
  logic [DATA_W-1:0] r_bus_wdata, w_bus_wdata_n;
  logic              r_snoop_flush, w_snoop_flush_n;
  logic [DATA_W-1:0] r_snoop_data, w_snoop_data_n;

  logic              w_hit, w_take, w_affect;
  logic              w_snp_wr, w_snp_flush;
  logic [LST_W-1:0]  w_snp_state;

  msi_cache_controller_snoop_logic #(.ADDR_W(ADDR_W)) u_snoop (
    .i_line_state (io_if.line_state_in),
    .i_line_addr  (io_if.line_addr_in),
    .i_snoop_cmd  (r_snp_cmd),
    .i_snoop_addr (r_snp_addr),
    .o_write_c    (w_snp_wr),
    .o_state_c    (w_snp_state),
    .o_flush_c    (w_snp_flush)
  );

  assign w_hit    = msi_is_valid(io_if.line_state_in) && (io_if.line_addr_in == r_addr);
  assign w_affect = w_snp_wr && (r_snp_addr[IDX_W-1:0] == r_addr[IDX_W-1:0]);
  // Snoops seen while we own the bus (gnt/done) are our own transaction echoed back.
  assign w_take   = io_if.snoop_valid &&
                    ((r_state == ST_IDLE) || (r_state == ST_LOOKUP) ||
                     (((r_state == ST_WB) || (r_state == ST_MISS)) &&
                      !io_if.bus_gnt && !io_if.bus_done));

  // Next state and registered outputs; line_idx keeps pointing at a line until its write lands.
  always_comb begin
    w_state_n       = r_state;
    w_ret_n         = r_ret;
    w_we_n          = r_we;
    w_addr_n        = r_addr;
    w_wdata_n       = r_wdata;
    w_fill_n        = r_fill;
    w_snp_cmd_n     = r_snp_cmd;
    w_snp_addr_n    = r_snp_addr;
    w_cpu_ready_n   = 1'b0;
    w_cpu_rdata_n   = r_cpu_rdata;
    w_line_idx_n    = r_line_idx;
    w_line_write_n  = 1'b0;
    w_line_state_n  = r_line_state;
    w_line_addr_n   = r_line_addr;
    w_line_data_n   = r_line_data;
    w_bus_req_n     = r_bus_req;
    w_bus_cmd_n     = r_bus_cmd;
    w_bus_addr_n    = r_bus_addr;
    w_bus_wdata_n   = r_bus_wdata;
    w_snoop_flush_n = 1'b0;
    w_snoop_data_n  = r_snoop_data;

    if (w_take) begin
      w_snp_cmd_n  = io_if.snoop_cmd;
      w_snp_addr_n = io_if.snoop_addr;
      w_line_idx_n = io_if.snoop_addr[IDX_W-1:0];
      w_ret_n      = ((r_state == ST_WB) || (r_state == ST_MISS)) ? r_state : ST_IDLE;
      w_state_n    = ST_SNOOP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_if.cpu_req && !r_cpu_ready) begin
            w_we_n       = io_if.cpu_we;
            w_addr_n     = io_if.cpu_addr;
            w_wdata_n    = io_if.cpu_wdata;
            w_line_idx_n = io_if.cpu_addr[IDX_W-1:0];
            w_state_n    = ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit && !r_we) begin
            w_cpu_ready_n = 1'b1;
            w_cpu_rdata_n = io_if.line_data_in;
            w_state_n     = ST_IDLE;
          end else if (w_hit && (io_if.line_state_in == MSI_M)) begin
            w_line_write_n = 1'b1;
            w_line_state_n = MSI_M;
            w_line_addr_n  = r_addr;
            w_line_data_n  = r_wdata;
            w_cpu_ready_n  = 1'b1;
            w_state_n      = ST_IDLE;
          end else if (!w_hit && (io_if.line_state_in == MSI_M)) begin
            w_bus_req_n   = 1'b1;
            w_bus_cmd_n   = CMD_WB;
            w_bus_addr_n  = io_if.line_addr_in;
            w_bus_wdata_n = io_if.line_data_in;
            w_state_n     = ST_WB;
          end else begin
            w_bus_req_n  = 1'b1;
            w_bus_cmd_n  = r_we ? CMD_RDX : CMD_BUSRD;
            w_bus_addr_n = r_addr;
            w_state_n    = ST_MISS;
          end
        end
        ST_WB: begin
          if (io_if.bus_done) begin
            w_line_write_n = 1'b1;
            w_line_state_n = MSI_I;
            w_line_addr_n  = r_bus_addr;
            w_line_data_n  = r_bus_wdata;
            w_line_idx_n   = r_addr[IDX_W-1:0];
            w_bus_req_n    = 1'b0;
            w_bus_cmd_n    = CMD_NONE;
            w_state_n      = ST_MISS;
          end
        end
        ST_MISS: begin
          if (io_if.bus_done) begin
            w_fill_n     = io_if.bus_rdata;
            w_line_idx_n = r_addr[IDX_W-1:0];
            w_bus_req_n  = 1'b0;
            w_bus_cmd_n  = CMD_NONE;
            w_state_n    = ST_FILL;
          end else if (!r_bus_req) begin
            w_bus_req_n  = 1'b1;
            w_bus_cmd_n  = r_we ? CMD_RDX : CMD_BUSRD;
            w_bus_addr_n = r_addr;
          end
        end
        ST_FILL: begin
          w_line_write_n = 1'b1;
          w_line_state_n = r_we ? MSI_M : MSI_S;
          w_line_addr_n  = r_addr;
          w_line_data_n  = r_we ? r_wdata : r_fill;
          w_cpu_ready_n  = 1'b1;
          if (!r_we) w_cpu_rdata_n = r_fill;
          w_state_n      = ST_IDLE;
        end
        ST_SNOOP: begin
          w_line_write_n  = w_snp_wr;
          w_line_state_n  = w_snp_state;
          w_line_addr_n   = io_if.line_addr_in;
          w_line_data_n   = io_if.line_data_in;
          w_snoop_flush_n = w_snp_flush;
          w_snoop_data_n  = io_if.line_data_in;
          // A changed victim/target line invalidates the pending plan: abandon and look up again.
          if (((r_ret == ST_WB) || (r_ret == ST_MISS)) && !w_affect) begin
            w_state_n = r_ret;
          end else begin
            if ((r_ret == ST_WB) || (r_ret == ST_MISS)) begin
              w_bus_req_n = 1'b0;
              w_bus_cmd_n = CMD_NONE;
            end
            w_state_n = ST_IDLE;
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_ret         <= ST_IDLE;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_fill        <= '0;
      r_snp_cmd     <= CMD_NONE;
      r_snp_addr    <= '0;
      r_cpu_ready   <= 1'b0;
      r_cpu_rdata   <= '0;
      r_line_idx    <= '0;
      r_line_write  <= 1'b0;
      r_line_state  <= MSI_I;
      r_line_addr   <= '0;
      r_line_data   <= '0;
      r_bus_req     <= 1'b0;
      r_bus_cmd     <= CMD_NONE;
      r_bus_addr    <= '0;
      r_bus_wdata   <= '0;
      r_snoop_flush <= 1'b0;
      r_snoop_data  <= '0;
    end else begin
      r_state       <= w_state_n;
      r_ret         <= w_ret_n;
      r_we          <= w_we_n;
      r_addr        <= w_addr_n;
      r_wdata       <= w_wdata_n;
      r_fill        <= w_fill_n;
      r_snp_cmd     <= w_snp_cmd_n;
      r_snp_addr    <= w_snp_addr_n;
      r_cpu_ready   <= w_cpu_ready_n;
      r_cpu_rdata   <= w_cpu_rdata_n;
      r_line_idx    <= w_line_idx_n;
      r_line_write  <= w_line_write_n;
      r_line_state  <= w_line_state_n;
      r_line_addr   <= w_line_addr_n;
      r_line_data   <= w_line_data_n;
      r_bus_req     <= w_bus_req_n;
      r_bus_cmd     <= w_bus_cmd_n;
      r_bus_addr    <= w_bus_addr_n;
      r_bus_wdata   <= w_bus_wdata_n;
      r_snoop_flush <= w_snoop_flush_n;
      r_snoop_data  <= w_snoop_data_n;
    end
  end

  assign io_if.cpu_ready   = r_cpu_ready;
  assign io_if.cpu_rdata   = r_cpu_rdata;
  assign io_if.line_idx    = r_line_idx;
  assign io_if.line_write  = r_line_write;
  assign io_if.line_state  = r_line_state;
  assign io_if.line_addr   = r_line_addr;
  assign io_if.line_data   = r_line_data;
  assign io_if.bus_req     = r_bus_req;
  assign io_if.bus_cmd     = r_bus_cmd;
  assign io_if.bus_addr    = r_bus_addr;
  assign io_if.bus_wdata   = r_bus_wdata;
  assign io_if.snoop_flush = r_snoop_flush;
  assign io_if.snoop_data  = r_snoop_data;

endmodule
